// File: rtl/instr_encoder.sv
// instr_encoder: packs RISC-V style field sets (R/I/S/B/U/J) into 32-bit
// instruction words. Each word is encoded when the request is accepted and
// then held in a small output FIFO.
// Optional feature macro: INSTR_ENCODER_RANGE_CHECK_EN.
//   Defined   -> out_err also flags immediates that do not fit their format.
//   Undefined -> immediates are silently truncated; only illegal fmt flags.

module instr_encoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [2:0]                    in_fmt,
    input  logic [6:0]                    in_opcode,
    input  logic [4:0]                    in_rd,
    input  logic [4:0]                    in_rs1,
    input  logic [4:0]                    in_rs2,
    input  logic [2:0]                    in_funct3,
    input  logic [6:0]                    in_funct7,
    input  logic [31:0]                   in_imm,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_instr,
    output logic                          out_err,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    // Buffer entry: {err, instr}
    typedef struct packed {
        logic        err;
        logic [31:0] instr;
    } entry_t;

    entry_t           mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    entry_t           enc;
    logic             range_err;
    logic             push;
    logic             pop;

    // Full check looks only at the registered count, so a same-cycle pop
    // cannot open the input and out_ready never reaches in_ready.
    assign in_ready  = (count < FULL_COUNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Output is driven from registered state only; zero while empty so a
    // freshly reset encoder never shows an uninitialised buffer slot.
    assign out_instr = out_valid ? mem[rd_ptr].instr : 32'h0;
    assign out_err   = out_valid ? mem[rd_ptr].err   : 1'b0;

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    // Flag immediates that cannot be represented exactly by their format.
    always_comb begin
        logic signed [31:0] imm_s;
        imm_s     = $signed(in_imm);
        range_err = 1'b0;
        case (in_fmt)
            FMT_I, FMT_S: range_err = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
            FMT_B:        range_err = (imm_s < -32'sd4096) || (imm_s > 32'sd4094)
                                      || in_imm[0];
            FMT_J:        range_err = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574)
                                      || in_imm[0];
            FMT_U:        range_err = (in_imm[11:0] != 12'h000);
            default:      range_err = 1'b0;
        endcase
    end
`else
    assign range_err = 1'b0;
`endif

    // Pack the request fields into one instruction word for the active format.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case leaves a value unassigned and no latch is inferred.
        enc.instr = NOP_WORD;
        enc.err   = range_err;
        case (in_fmt)
            FMT_R: enc.instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
            FMT_I: enc.instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            FMT_S: enc.instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                                in_imm[4:0], in_opcode};
            FMT_B: enc.instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                in_imm[4:1], in_imm[11], in_opcode};
            FMT_U: enc.instr = {in_imm[31:12], in_rd, in_opcode};
            FMT_J: enc.instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                                in_rd, in_opcode};
            default: begin
                enc.instr = NOP_WORD;
                enc.err   = 1'b1;
            end
        endcase
    end

    // Store the encoded word in the buffer slot addressed by the write pointer.
    always_ff @(posedge clk) begin
        // NOTE: the buffer array is not reset; count gates visibility, and
        // out_instr/out_err read zero until a slot has actually been written.
        if (!reset && push) begin
            mem[wr_ptr] <= enc;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo FIFO_DEPTH.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed testbench for instr_encoder: encoding table, FIFO fill/drain,
// simultaneous push/pop and reset behaviour.

module tb_instr_encoder;

    localparam int FIFO_DEPTH = 4;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    localparam logic RC = 1'b1;
`else
    localparam logic RC = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_fmt;
    logic [6:0]       in_opcode;
    logic [4:0]       in_rd;
    logic [4:0]       in_rs1;
    logic [4:0]       in_rs2;
    logic [2:0]       in_funct3;
    logic [6:0]       in_funct7;
    logic [31:0]      in_imm;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic             out_err;
    logic [CNT_W-1:0] count;

    int n_cmp;
    int n_fail;

    instr_encoder #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] fmt, input logic [6:0] op,
                         input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm);
        in_valid  = 1'b1;
        in_fmt    = fmt;
        in_opcode = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
    endtask

    // addi-style word with rd = imm = k, rs1 = 0.
    task automatic drive_addi(input int k);
        drive(3'd1, 7'h13, 5'(k), 5'd0, 5'd0, 3'd0, 7'd0, 32'(k));
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        in_valid  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_cmp++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_out_instr: got %h expected 00000000", out_instr); end
        n_cmp++; if (out_err !== 1'b0) begin n_fail++; $display("FAIL reset_out_err: got %b expected 0", out_err); end
    endtask

    task automatic test_formats();
        vec_t v[12];
        v[0]  = '{"i_addi",    3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5,          32'h00500093, 1'b0};
        v[1]  = '{"s_sw",      3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'd8,          32'h0020A423, 1'b0};
        v[2]  = '{"b_neg4",    3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFC,   32'hFE000EE3, 1'b0};
        v[3]  = '{"j_jal",     3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd8,          32'h008000EF, 1'b0};
        v[4]  = '{"u_lui",     3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000,   32'h123452B7, 1'b0};
        v[5]  = '{"r_add",     3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0,          32'h002081B3, 1'b0};
        v[6]  = '{"r_sub",     3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEADBEEF,   32'h402081B3, 1'b0};
        v[7]  = '{"i_imm2048", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048,       32'h80000093, RC};
        v[8]  = '{"b_odd",     3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3,          32'h00000163, RC};
        v[9]  = '{"u_lowbits", 3'd4, 7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00001FFF,   32'h00001037, RC};
        v[10] = '{"fmt7",      3'd7, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0,          32'h00000013, 1'b1};
        v[11] = '{"fmt6",      3'd6, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd8,          32'h00000013, 1'b1};
        out_ready = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive(v[i].fmt, v[i].op, v[i].rd, v[i].rs1, v[i].rs2, v[i].f3, v[i].f7, v[i].imm);
            #1;
            n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_no_bypass: out_valid got %b expected 0", v[i].name, out_valid); end
            tick();
            in_valid = 1'b0;
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL %s_valid: got %b expected 1", v[i].name, out_valid); end
            n_cmp++; if (out_instr !== v[i].exp_instr) begin n_fail++; $display("FAIL %s_instr: got %h expected %h", v[i].name, out_instr, v[i].exp_instr); end
            n_cmp++; if (out_err !== v[i].exp_err) begin n_fail++; $display("FAIL %s_err: got %b expected %b", v[i].name, out_err, v[i].exp_err); end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL %s_popped: count got %0d expected 0", v[i].name, count); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_words[4];
        int          accepted;
        exp_words = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213};
        accepted  = 0;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive_addi(k + 1);
            #1;
            if (in_ready === 1'b1) accepted++;
            n_cmp++;
            if (in_ready !== (k < 4)) begin n_fail++; $display("FAIL b2b_in_ready_req%0d: got %b expected %b", k, in_ready, (k < 4)); end
            tick();
        end
        in_valid = 1'b0;
        n_cmp++; if (accepted != 4) begin n_fail++; $display("FAIL b2b_accepted: got %0d expected 4", accepted); end
        n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL b2b_count_full: got %0d expected 4", count); end
        tick();
        tick();
        n_cmp++; if (out_instr !== exp_words[0]) begin n_fail++; $display("FAIL b2b_head_stable: got %h expected %h", out_instr, exp_words[0]); end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_pop_in_ready: got %b expected 0", in_ready); end
        for (int j = 0; j < 4; j++) begin
            n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_drain%0d_valid: got %b expected 1", j, out_valid); end
            n_cmp++; if (out_instr !== exp_words[j]) begin n_fail++; $display("FAIL b2b_drain%0d_instr: got %h expected %h", j, out_instr, exp_words[j]); end
            tick();
        end
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty_valid: got %b expected 0", out_valid); end
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL b2b_empty_count: got %0d expected 0", count); end
    endtask

    task automatic test_simultaneous();
        out_ready = 1'b0;
        drive_addi(1);
        tick();
        drive_addi(2);
        tick();
        n_cmp++; if (count !== 3'd2) begin n_fail++; $display("FAIL sim_pre_count: got %0d expected 2", count); end
        drive_addi(3);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (count !== 3'd2) begin n_fail++; $display("FAIL sim_count_held: got %0d expected 2", count); end
        n_cmp++; if (out_instr !== 32'h00200113) begin n_fail++; $display("FAIL sim_head1: got %h expected 00200113", out_instr); end
        tick();
        n_cmp++; if (out_instr !== 32'h00300193) begin n_fail++; $display("FAIL sim_head2: got %h expected 00300193", out_instr); end
        n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL sim_count1: got %0d expected 1", count); end
        tick();
        out_ready = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL sim_count0: got %0d expected 0", count); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            drive_addi(k);
            tick();
        end
        in_valid = 1'b0;
        n_cmp++; if (count !== 3'd3) begin n_fail++; $display("FAIL rmid_pre_count: got %0d expected 3", count); end
        drive_addi(7);
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL rmid_count: got %0d expected 0", count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready: got %b expected 1", in_ready); end
        n_cmp++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL rmid_out_instr: got %h expected 00000000", out_instr); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL rmid_no_stale: count got %0d expected 0", count); end
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_no_stale_valid: got %b expected 0", out_valid); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_formats();
        test_back_to_back();
        test_simultaneous();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
